// File: rtl/matrix_pkg.sv
// Shared constants, scan-state encoding and frame slicing helper for the 5x7 LED matrix driver.
package matrix_pkg;

    localparam int unsigned MTX_COLS    = 5;
    localparam int unsigned MTX_LINES   = 7;
    localparam int unsigned MTX_FRAME_W = MTX_COLS * MTX_LINES;
    localparam int unsigned MTX_IDX_W   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StDrive
    } scan_state_e;

    // Lines of column k: frame[7*k +: 7].
    function automatic logic [MTX_LINES-1:0] col_slice(
        input logic [MTX_FRAME_W-1:0] frame,
        input logic [MTX_IDX_W-1:0]   k
    );
        logic [MTX_FRAME_W-1:0] shifted;
        shifted = frame >> (MTX_LINES * int'(k));
        return shifted[MTX_LINES-1:0];
    endfunction

endpackage

// File: rtl/matrix_scan_driver.sv
// Time-multiplexed 5x7 LED matrix scanner with a double-buffered frame, per-column blanking
// gap and dwell time; every output is registered.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int unsigned DWELL           = 50000,
    parameter int unsigned BLANK           = 16,
    parameter bit          COL_ACTIVE_LOW  = 1'b1,
    parameter bit          LINE_ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [MTX_FRAME_W-1:0] frame_in,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    output logic [MTX_COLS-1:0]    col,
    output logic [MTX_LINES-1:0]   line,
    output logic                   frame_sync
);

    localparam int unsigned          MAX_CNT    = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned          CNT_W      = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0]     BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [MTX_IDX_W-1:0] LAST_COL   = MTX_IDX_W'(MTX_COLS - 1);
    localparam logic [MTX_COLS-1:0]  COL_OFF    = {MTX_COLS{COL_ACTIVE_LOW}};
    localparam logic [MTX_LINES-1:0] LINE_OFF   = {MTX_LINES{LINE_ACTIVE_LOW}};

    scan_state_e            r_state;
    logic [MTX_IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [MTX_FRAME_W-1:0] r_active;
    logic [MTX_FRAME_W-1:0] r_pending;
    logic                   r_pending_full;

    scan_state_e            w_state;
    logic [MTX_IDX_W-1:0]   w_idx;
    logic [CNT_W-1:0]       w_cnt;
    logic                   w_boundary;
    logic                   w_load;
    logic                   w_swap;
    logic [MTX_FRAME_W-1:0] w_active;
    logic [MTX_FRAME_W-1:0] w_pending;
    logic                   w_pending_full;
    logic [MTX_COLS-1:0]    w_col;
    logic [MTX_LINES-1:0]   w_line;

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_boundary = 1'b0;
        if (!enable) begin
            w_state = StIdle;
            w_idx   = '0;
            w_cnt   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state    = StBlank;
                    w_idx      = '0;
                    w_cnt      = '0;
                    w_boundary = 1'b1;
                end
                StBlank: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state = StDrive;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                StDrive: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_state = StBlank;
                        w_cnt   = '0;
                        if (r_idx == LAST_COL) begin
                            w_idx      = '0;
                            w_boundary = 1'b1;
                        end else begin
                            w_idx = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                default: w_state = StIdle;
            endcase
        end
    end

    // Swap sees the pre-edge pending state; a frame loaded on the boundary edge waits a frame.
    always_comb begin
        w_load         = frame_valid && !r_pending_full;
        w_swap         = w_boundary && r_pending_full;
        w_active       = w_swap ? r_pending : r_active;
        w_pending      = w_load ? frame_in : r_pending;
        w_pending_full = w_swap ? 1'b0 : (w_load ? 1'b1 : r_pending_full);
        w_col          = COL_OFF;
        w_line         = LINE_OFF;
        if (w_state == StDrive) begin
            w_col  = COL_OFF ^ (MTX_COLS'(1) << w_idx);
            w_line = LINE_OFF ^ col_slice(w_active, w_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_active       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            col            <= COL_OFF;
            line           <= LINE_OFF;
            frame_ready    <= 1'b1;
            frame_sync     <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_idx          <= w_idx;
            r_cnt          <= w_cnt;
            r_active       <= w_active;
            r_pending      <= w_pending;
            r_pending_full <= w_pending_full;
            col            <= w_col;
            line           <= w_line;
            frame_ready    <= !w_pending_full;
            frame_sync     <= w_boundary;
        end
    end

endmodule
